// File: rtl/seg_scan_if.sv
// Bundle between the scan controller and its host/decoder stage:
// display value and controls in, digit select / nibble / enable out.
interface seg_scan_if #(
    parameter int NDIG = 8
);
    logic [31:0]     value;
    logic            load;
    logic [7:0]      digit_mask;
    logic            lz_en;
    logic [NDIG-1:0] an;
    logic [3:0]      num;
    logic            en;
    logic            frame_done;

    modport master (
        output value, load, digit_mask, lz_en,
        input  an, num, en, frame_done
    );

    modport slave (
        input  value, load, digit_mask, lz_en,
        output an, num, en, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one hex digit per slot,
// frame-aligned value commit, leading-zero blanking and per-digit mask.
module seg_scan_ctrl #(
    parameter int NDIG = 8,
    parameter int DIV  = 50000
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int VW = 4 * NDIG;

    logic [PW-1:0]   presc, presc_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [VW-1:0]   pending, shadow, shadow_nxt;
    logic            pend_valid;
    logic            tick, last, boundary;
    logic [NDIG-1:0] lzb;

    logic [NDIG-1:0] an_r, an_nxt;
    logic [3:0]      num_r, num_nxt;
    logic            en_r, en_nxt;
    logic            fd_r, fd_nxt;

    always_comb begin
        tick      = (presc == PW'(DIV - 1));
        last      = (idx == IW'(NDIG - 1));
        boundary  = tick && last;
        presc_nxt = tick ? '0 : presc + 1'b1;
        idx_nxt   = idx;
        if (tick) begin
            idx_nxt = last ? '0 : idx + 1'b1;
        end
        shadow_nxt = (boundary && pend_valid) ? pending : shadow;
    end

    // Scan from the top nibble down; a digit is blanked while everything
    // above it (and itself) is zero. Digit 0 is exempt.
    always_comb begin
        logic        zacc;
        int unsigned d;
        lzb  = '0;
        zacc = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            d    = NDIG - 1 - k;
            zacc = zacc && (shadow_nxt[4*d +: 4] == 4'h0);
            lzb[d] = bus.lz_en && (d != 0) && zacc;
        end
    end

    // Outputs are looked up from next-state counters so they line up with
    // the slot they describe; presc==0 is the anti-ghosting guard cycle.
    always_comb begin
        an_nxt  = '1;
        en_nxt  = 1'b0;
        num_nxt = shadow_nxt[4*idx_nxt +: 4];
        if (presc_nxt != '0) begin
            an_nxt = ~(NDIG'(1) << idx_nxt);
            en_nxt = bus.digit_mask[idx_nxt] & ~lzb[idx_nxt];
        end
        fd_nxt = (presc_nxt == PW'(DIV - 1)) && (idx_nxt == IW'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            shadow     <= '0;
            an_r       <= '1;
            num_r      <= '0;
            en_r       <= 1'b0;
            fd_r       <= 1'b0;
        end else begin
            presc  <= presc_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            if (bus.load) begin
                pending    <= bus.value[VW-1:0];
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
            an_r  <= an_nxt;
            num_r <= num_nxt;
            en_r  <= en_nxt;
            fd_r  <= fd_nxt;
        end
    end

    assign bus.an         = an_r;
    assign bus.num        = num_r;
    assign bus.en         = en_r;
    assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (NDIG=8, DIV=4): directed scenarios plus random
// traffic, checked every cycle against a slot/frame reference model.
module tb_seg_scan_ctrl;
    localparam int NDIG  = 8;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: cycles since reset, committed/pending values, and
    // the controls as seen at the last edge.
    int          t;
    logic        m_rst;
    logic [31:0] m_pend, m_shadow;
    logic        m_valid;
    logic [7:0]  m_mask;
    logic        m_lz;

    logic [7:0]  cur_mask;
    logic        cur_lz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic check_now();
        int          pos, dig, ph;
        logic [31:0] upper;
        logic [7:0]  exp_an;
        logic        exp_en;
        pos = t % FRAME;
        dig = pos / DIV;
        ph  = pos % DIV;
        upper = m_shadow >> (4 * dig);
        chk("frame_done", 32'(bus.frame_done), 32'(!m_rst && pos == FRAME - 1));
        if (ph == 0) begin
            chk("an_guard", 32'(bus.an), 32'hFF);
            chk("en_guard", 32'(bus.en), 32'h0);
            if (m_rst) chk("num_reset", 32'(bus.num), 32'h0);
        end else begin
            exp_an = 8'hFF;
            exp_an[dig] = 1'b0;
            exp_en = m_mask[dig] && !(m_lz && dig != 0 && upper == 32'h0);
            chk("an", 32'(bus.an), 32'(exp_an));
            chk("num", 32'(bus.num), upper & 32'hF);
            chk("en", 32'(bus.en), 32'(exp_en));
        end
    endtask

    // Check the current cycle, then drive inputs for it and advance the model.
    task automatic step(input logic rn, input logic ld, input logic [31:0] v);
        check_now();
        rst_n          = rn;
        bus.load       = ld;
        bus.value      = v;
        bus.digit_mask = cur_mask;
        bus.lz_en      = cur_lz;
        if (!rn) begin
            m_pend = '0; m_valid = 1'b0; m_shadow = '0;
            t = 0; m_rst = 1'b1;
        end else begin
            if (t % FRAME == FRAME - 1) begin
                if (m_valid) m_shadow = m_pend;
                m_valid = 1'b0;
            end
            if (ld) begin
                m_pend  = v;
                m_valid = 1'b1;
            end
            t++;
            m_rst = 1'b0;
        end
        m_mask = cur_mask;
        m_lz   = cur_lz;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        cur_mask = 8'hFF;
        cur_lz   = 1'b0;
        rst_n = 1'b0;
        bus.load = 1'b0; bus.value = '0; bus.digit_mask = 8'hFF; bus.lz_en = 1'b0;
        m_pend = '0; m_valid = 1'b0; m_shadow = '0; t = 0; m_rst = 1'b1;
        m_mask = 8'hFF; m_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset hold and plain scan of zeros
        do_reset(3);
        idle(2);
        // Commit: load at cycle 2 shows up in frame 1
        step(1'b1, 1'b1, 32'h1234ABCD);
        idle(2 * FRAME);

        // Leading-zero blanking
        cur_lz = 1'b1;
        step(1'b1, 1'b1, 32'h00000A05);
        idle(2 * FRAME);
        step(1'b1, 1'b1, 32'h0);
        idle(2 * FRAME);
        cur_lz = 1'b0;

        // Two loads in one frame, then a load on the frame_done cycle
        run_to(3);
        step(1'b1, 1'b1, 32'h11111111);
        idle(5);
        step(1'b1, 1'b1, 32'h22222222);
        idle(FRAME);
        run_to(FRAME - 1);
        step(1'b1, 1'b1, 32'h5A5A5A5A);
        idle(2 * FRAME + 3);

        // Per-digit mask
        cur_mask = 8'h0F;
        idle(2 * FRAME);
        cur_mask = 8'hFF;

        // Reset mid-scan with a pending value
        step(1'b1, 1'b1, 32'hCAFEF00D);
        run_to(5 * DIV + 2);
        do_reset(1);
        idle(2 * FRAME + 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] v;
            if ($urandom_range(0, 59) == 0) cur_mask = 8'($urandom);
            if ($urandom_range(0, 79) == 0) cur_lz = ~cur_lz;
            v = $urandom >> (4 * $urandom_range(0, 8));
            step(($urandom_range(0, 399) != 0), ($urandom_range(0, 11) == 0), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
